i2c_target: RTL

I2C target (slave) endpoint: the far end of the bit-banged I2C bus that the CR16 drives through the external memory-mapped SCL/SDA registers. It synchronizes SCL/SDA, detects START/STOP, matches a 7-bit address, and ACKs it. It then either delivers received bytes to fabric logic or serializes fabric-supplied bytes back to the initiator. SDA is open-drain: the block only ever pulls it low or releases it.

---
 rtl/i2c_target.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_target.sv
// I2C target endpoint: synchronizes SCL/SDA, matches a 7-bit address and
// moves bytes between the bus and fabric through an open-drain SDA driver.
module i2c_target #(
  parameter logic [6:0] P_TARGET_ADDRESS = 7'h42,
  parameter int         P_SYNC_STAGES    = 2
) (
  input  logic       I_CLK,
  input  logic       I_NRESET,
  input  logic       I_SCL,
  inout  wire        IO_SDA,
  input  logic [7:0] I_TX_DATA,
  output logic [7:0] O_RX_DATA,
  output logic       O_RX_VALID,
  output logic       O_TX_LOAD,
  output logic       O_BUSY
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ADDR      = 3'd1,
    ADDR_ACK  = 3'd2,
    WR_DATA   = 3'd3,
    WR_ACK    = 3'd4,
    RD_DATA   = 3'd5,
    RD_ACK    = 3'd6,
    WAIT_STOP = 3'd7
  } state_t;

  logic [P_SYNC_STAGES-1:0] scl_sync_r, sda_sync_r;
  logic scl_prev_r, sda_prev_r;
  logic scl_s, sda_s, scl_rise_s, scl_fall_s, start_s, stop_s;

  state_t     state_r, state_s;
  logic [3:0] bit_cnt_r, bit_cnt_s;
  logic [7:0] shift_r, shift_s;
  logic [7:0] rx_data_r, rx_data_s;
  logic       rw_r, rw_s;
  logic       sda_oe_r, sda_oe_s;
  logic       busy_r, busy_s;
  logic       rx_valid_r, rx_valid_s;
  logic       tx_load_r, tx_load_s;

  assign scl_s      = scl_sync_r[P_SYNC_STAGES-1];
  assign sda_s      = sda_sync_r[P_SYNC_STAGES-1];
  assign scl_rise_s = scl_s & ~scl_prev_r;
  assign scl_fall_s = ~scl_s & scl_prev_r;
  // START/STOP are SDA edges while SCL stays high across both samples
  assign start_s    = scl_s & scl_prev_r & sda_prev_r & ~sda_s;
  assign stop_s     = scl_s & scl_prev_r & ~sda_prev_r & sda_s;

  // Input synchronizers plus edge-history flops; reset to the idle-bus level
  always_ff @(posedge I_CLK) begin
    if (!I_NRESET) begin
      scl_sync_r <= {P_SYNC_STAGES{1'b1}};
      sda_sync_r <= {P_SYNC_STAGES{1'b1}};
      scl_prev_r <= 1'b1;
      sda_prev_r <= 1'b1;
    end else begin
      scl_sync_r <= {scl_sync_r[P_SYNC_STAGES-2:0], I_SCL};
      sda_sync_r <= {sda_sync_r[P_SYNC_STAGES-2:0], IO_SDA};
      scl_prev_r <= scl_s;
      sda_prev_r <= sda_s;
    end
  end

  // Protocol state and datapath registers
  always_ff @(posedge I_CLK) begin
    if (!I_NRESET) begin
      state_r    <= IDLE;
      bit_cnt_r  <= 4'd0;
      shift_r    <= 8'h00;
      rx_data_r  <= 8'h00;
      rw_r       <= 1'b0;
      sda_oe_r   <= 1'b0;
      busy_r     <= 1'b0;
      rx_valid_r <= 1'b0;
      tx_load_r  <= 1'b0;
    end else begin
      state_r    <= state_s;
      bit_cnt_r  <= bit_cnt_s;
      shift_r    <= shift_s;
      rx_data_r  <= rx_data_s;
      rw_r       <= rw_s;
      sda_oe_r   <= sda_oe_s;
      busy_r     <= busy_s;
      rx_valid_r <= rx_valid_s;
      tx_load_r  <= tx_load_s;
    end
  end

  // Next-state and output decode; bus conditions override SCL edges
  always_comb begin
    state_s    = state_r;
    bit_cnt_s  = bit_cnt_r;
    shift_s    = shift_r;
    rx_data_s  = rx_data_r;
    rw_s       = rw_r;
    sda_oe_s   = sda_oe_r;
    busy_s     = busy_r;
    rx_valid_s = 1'b0;
    tx_load_s  = 1'b0;
    if (stop_s) begin
      state_s   = IDLE;
      bit_cnt_s = 4'd0;
      sda_oe_s  = 1'b0;
      busy_s    = 1'b0;
    end else if (start_s) begin
      // busy is kept so a repeated START to this target does not glitch it
      state_s   = ADDR;
      bit_cnt_s = 4'd0;
      sda_oe_s  = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          state_s = IDLE;
        end
        ADDR: begin
          if (scl_rise_s) begin
            shift_s = {shift_r[6:0], sda_s};
            if (bit_cnt_r == 4'd7) begin
              bit_cnt_s = 4'd0;
              if (shift_r[6:0] == P_TARGET_ADDRESS) begin
                state_s = ADDR_ACK;
                rw_s    = sda_s;
                busy_s  = 1'b1;
              end else begin
                state_s = WAIT_STOP;
                busy_s  = 1'b0;
              end
            end else begin
              bit_cnt_s = bit_cnt_r + 4'd1;
            end
          end else begin
            state_s = ADDR;
          end
        end
        ADDR_ACK: begin
          if (scl_fall_s) begin
            if (!sda_oe_r) begin
              sda_oe_s = 1'b1;
              busy_s   = 1'b1;
            end else if (!rw_r) begin
              sda_oe_s  = 1'b0;
              state_s   = WR_DATA;
              bit_cnt_s = 4'd0;
            end else begin
              tx_load_s = 1'b1;
              shift_s   = I_TX_DATA;
              sda_oe_s  = ~I_TX_DATA[7];
              bit_cnt_s = 4'd1;
              state_s   = RD_DATA;
            end
          end else begin
            state_s = ADDR_ACK;
          end
        end
        WR_DATA: begin
          if (scl_rise_s) begin
            shift_s = {shift_r[6:0], sda_s};
            if (bit_cnt_r == 4'd7) begin
              bit_cnt_s  = 4'd0;
              rx_data_s  = {shift_r[6:0], sda_s};
              rx_valid_s = 1'b1;
              state_s    = WR_ACK;
            end else begin
              bit_cnt_s = bit_cnt_r + 4'd1;
            end
          end else begin
            state_s = WR_DATA;
          end
        end
        WR_ACK: begin
          if (scl_fall_s) begin
            if (!sda_oe_r) begin
              sda_oe_s = 1'b1;
            end else begin
              sda_oe_s  = 1'b0;
              state_s   = WR_DATA;
              bit_cnt_s = 4'd0;
            end
          end else begin
            state_s = WR_ACK;
          end
        end
        RD_DATA: begin
          // bit_cnt counts bits already placed on the bus
          if (scl_fall_s) begin
            if (bit_cnt_r == 4'd8) begin
              sda_oe_s  = 1'b0;
              bit_cnt_s = 4'd0;
              state_s   = RD_ACK;
            end else begin
              sda_oe_s  = ~shift_r[6];
              shift_s   = {shift_r[6:0], 1'b0};
              bit_cnt_s = bit_cnt_r + 4'd1;
            end
          end else begin
            state_s = RD_DATA;
          end
        end
        RD_ACK: begin
          if (scl_rise_s) begin
            if (sda_s) begin
              state_s = WAIT_STOP;
              busy_s  = 1'b0;
            end else begin
              state_s = RD_ACK;
            end
          end else if (scl_fall_s) begin
            tx_load_s = 1'b1;
            shift_s   = I_TX_DATA;
            sda_oe_s  = ~I_TX_DATA[7];
            bit_cnt_s = 4'd1;
            state_s   = RD_DATA;
          end else begin
            state_s = RD_ACK;
          end
        end
        WAIT_STOP: begin
          state_s = WAIT_STOP;
        end
        default: begin
          state_s   = IDLE;
          bit_cnt_s = 4'd0;
          sda_oe_s  = 1'b0;
          busy_s    = 1'b0;
        end
      endcase
    end
  end

  assign IO_SDA     = sda_oe_r ? 1'b0 : 1'bz;
  assign O_RX_DATA  = rx_data_r;
  assign O_RX_VALID = rx_valid_r;
  assign O_TX_LOAD  = tx_load_r;
  assign O_BUSY     = busy_r;

endmodule
